rst_sequencer: RTL and testbench
================================

Name: rst_sequencer

Overview:
- Parametrised reset controller for the SoC.
- Generates a counted power-on reset, then releases NUM_DOMAINS reset domains in order: core memories first, then core, then peripherals.
- Accepts a debounced external reset button and a software reset request from the core, and re-runs the release sequence after either.
- Reports the cause of the last reset. Sits directly under priRV32_SoC and feeds every rst_n in the design.

Parameters:
- POR_CYCLES, 500_000: cycles held in power-on reset (10 ms at 50 MHz); minimum 1.
- NUM_DOMAINS, 3: number of staged reset outputs; minimum 1.
- STAGE_CYCLES, 16: cycles between consecutive domain releases; minimum 1.
- DEBOUNCE_CYCLES, 50_000: cycles the synchronised button level must stay stable before it is accepted.
- HOLD_CYCLES, 1_000: minimum cycles all domains stay asserted after a button or software reset.
- BTN_ACTIVE_LOW, 1: 1 means the button is pressed when btn_rst_in=0.
- WDT_CYCLES, 50_000_000: watchdog timeout (optional feature only).

Ports:
- clk_in  input  1: system clock.
- rst_n  input  1: synchronous active-low hard reset (e.g. PLL not locked).
- btn_rst_in  input  1: raw, asynchronous external button.
- sw_rst_req  input  1: single-cycle software reset request from the core.
- wdt_kick  input  1: watchdog refresh pulse.
- rst_out_n  output  NUM_DOMAINS: per-domain synchronous active-low resets.
- rst_done  output  1: high when all domains are released.
- rst_cause  output  2: cause of the last reset. 0 = power-on/hard, 1 = button, 2 = software, 3 = watchdog.

Behaviour:
- Clock and reset: one clock, clk_in. rst_n is synchronous and active-low; it is sampled only on the rising edge of clk_in.
- State while rst_n=0:
  - state=S_POR, counter=0, rst_out_n=all 0, rst_done=0, rst_cause=0.
  - Debouncer output=released; synchroniser flops at the released level; watchdog counter=0.
- Button input path:
  - btn_rst_in passes through a 2-flop synchroniser, then the debouncer.
  - The debounced level changes only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce reloads the count.
  - A press event is the debounced transition from released to pressed.
- Counter: a single shared counter, width $clog2 of the largest count parameter, plus 1 bit.
- FSM states:
  - S_POR: counter increments each cycle. On the edge where counter==POR_CYCLES-1: rst_out_n[0]<=1, counter<=0, go to S_RELEASE. Requests are ignored in this state.
  - S_RELEASE: every STAGE_CYCLES cycles, release the next domain in ascending index. Once a domain is released it stays released until a new reset. On the edge that releases domain NUM_DOMAINS-1: rst_done<=1, go to S_RUN. With NUM_DOMAINS=1, S_POR goes directly to S_RUN and asserts rst_done on that same edge.
  - S_RUN: all domains released. A press event, sw_rst_req, or (optionally) watchdog expiry causes rst_out_n<=all 0, rst_done<=0, rst_cause updated, counter<=0, go to S_ASSERT.
  - S_ASSERT: counter increments but reloads to 0 while the button is debounced-pressed. On the edge where counter==HOLD_CYCLES-1 with the button released: rst_out_n[0]<=1, go to S_RELEASE.
- Latency:
  - rst_out_n[k] rises POR_CYCLES + k*STAGE_CYCLES edges after the first edge that samples rst_n=1.
  - After a request accepted in S_RUN, all outputs fall on the next edge.
- Requests in S_RELEASE: a press event or sw_rst_req is also accepted in S_RELEASE. It drops all outputs and enters S_ASSERT, so a partial release is aborted.
- Simultaneous requests: cause priority is button > watchdog > software. sw_rst_req in S_POR or S_ASSERT is dropped, not queued.
- rst_cause is held until the next reset event; only rst_n clears it.
- Outputs: all outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: RST_WDT_EN.
- Defined:
  - A watchdog counter runs only in S_RUN.
  - wdt_kick or leaving S_RUN clears it to 0.
  - Reaching WDT_CYCLES-1 triggers a reset with cause 3.
- Not defined:
  - No watchdog logic is built; wdt_kick is ignored and cause 3 never appears.
  - The port list is unchanged.

Decomposition:
- Package rst_seq_pkg contains:
  - State encodings S_POR, S_RELEASE, S_RUN, S_ASSERT.
  - Cause codes CAUSE_POR, CAUSE_BTN, CAUSE_SW, CAUSE_WDT.
  - The counter-width function.
- Sub-module rst_debounce contains the synchroniser plus debouncer. It is parametrised by DEBOUNCE_CYCLES and BTN_ACTIVE_LOW, and outputs pressed_level and press_pulse.

Test Plan:
- Common parameters: POR_CYCLES=10, NUM_DOMAINS=3, STAGE_CYCLES=4, DEBOUNCE_CYCLES=8, HOLD_CYCLES=6.
- Power-on: deassert rst_n at edge 0 -> rst_out_n = 001 at edge 10, 011 at 14, 111 at 18; rst_done=1 at 18; rst_cause=0.
- Software reset: sw_rst_req pulse in S_RUN -> rst_out_n=000 on the next edge; 001 after 6 more edges; 111 after 8 more; rst_cause=2.
- Button bounce: btn_rst_in low for 5 cycles, high for 2, low for 20 -> exactly one press event, 8 cycles after the final falling edge. Outputs stay low until release + 6 cycles; rst_cause=1.
- Abort during release: sw_rst_req when rst_out_n=011 -> next edge 000, then a full restart of the S_ASSERT and S_RELEASE sequence.
- Hard reset mid-run: rst_n=0 for 1 cycle while in S_RUN -> outputs 000, rst_cause=0, a full 10-cycle power-on sequence follows.
- Watchdog (RST_WDT_EN, WDT_CYCLES=20): no kick for 20 cycles in S_RUN -> reset with rst_cause=3. Kicking every 15 cycles -> no reset.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types and helpers for the reset sequencer
// Contents: FSM state encoding, reset cause codes, counter width helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        S_POR     = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2,
        S_ASSERT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'd0,
        CAUSE_BTN = 2'd1,
        CAUSE_SW  = 2'd2,
        CAUSE_WDT = 2'd3
    } cause_t;

    // Width able to hold the largest of three terminal counts, plus one
    // spare bit of headroom.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// rtl/rst_sequencer_if.sv - request inputs and staged reset outputs of the sequencer
// master: the sequencer (samples btn_rst_in/sw_rst_req/wdt_kick, drives
//         rst_out_n/rst_done/rst_cause)
// slave:  the SoC side that raises requests and consumes the resets
interface rst_sequencer_if
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 3
);
    logic                   btn_rst_in;
    logic                   sw_rst_req;
    logic                   wdt_kick;
    logic [NUM_DOMAINS-1:0] rst_out_n;
    logic                   rst_done;
    cause_t                 rst_cause;

    modport master (
        input  btn_rst_in,
        input  sw_rst_req,
        input  wdt_kick,
        output rst_out_n,
        output rst_done,
        output rst_cause
    );

    modport slave (
        output btn_rst_in,
        output sw_rst_req,
        output wdt_kick,
        input  rst_out_n,
        input  rst_done,
        input  rst_cause
    );
endinterface

// File: rtl/rst_debounce.sv
// rtl/rst_debounce.sv - button synchroniser and debouncer
// Ports: clk_in, rst_n (sync, active-low), btn_rst_in (raw async button),
//        pressed_level (debounced, 1 = pressed), press_pulse (one cycle on
//        the debounced released->pressed transition, aligned with the
//        rising edge of pressed_level).
module rst_debounce
    import rst_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic btn_rst_in,
    output logic pressed_level,
    output logic press_pulse
);
    localparam int            DW       = cnt_width(DEBOUNCE_CYCLES, 1, 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    // Raw level of an untouched button.
    localparam logic          IDLE_RAW = BTN_ACTIVE_LOW;

    logic          sync1;
    logic          sync2;
    logic          sync_pressed;
    logic [DW-1:0] cnt;

    assign sync_pressed = sync2 ^ BTN_ACTIVE_LOW;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync1         <= IDLE_RAW;
            sync2         <= IDLE_RAW;
            cnt           <= '0;
            pressed_level <= 1'b0;
            press_pulse   <= 1'b0;
        end else begin
            sync1       <= btn_rst_in;
            sync2       <= sync1;
            press_pulse <= 1'b0;
            // Count consecutive cycles of disagreement; any agreement
            // (a bounce back) restarts the count.
            if (sync_pressed == pressed_level) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                pressed_level <= sync_pressed;
                press_pulse   <= sync_pressed;
                cnt           <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - counted power-on reset and staged domain release
// Ports: clk_in (system clock), rst_n (sync active-low hard reset),
//        bus (rst_sequencer_if.master: btn_rst_in, sw_rst_req, wdt_kick in;
//        rst_out_n[NUM_DOMAINS], rst_done, rst_cause out, all registered).
// Optional macro RST_WDT_EN builds the watchdog (cause 3); without it
// wdt_kick is ignored.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int POR_CYCLES      = 500_000,
    parameter int NUM_DOMAINS     = 3,
    parameter int STAGE_CYCLES    = 16,
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int HOLD_CYCLES     = 1_000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int WDT_CYCLES      = 50_000_000
) (
    input  logic            clk_in,
    input  logic            rst_n,
    rst_sequencer_if.master bus
);
    localparam int            CW         = cnt_width(POR_CYCLES, STAGE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] POR_LAST   = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [NUM_DOMAINS-1:0] FIRST_MASK = NUM_DOMAINS'(1);

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [NUM_DOMAINS-1:0] out_n_q;
    logic [NUM_DOMAINS-1:0] next_mask;
    logic                   done_q;
    cause_t                 cause_q;
    cause_t                 req_cause;
    logic                   btn_level;
    logic                   btn_press;
    logic                   wdt_fire;
    logic                   req_any;

    rst_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_debounce (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .btn_rst_in   (bus.btn_rst_in),
        .pressed_level(btn_level),
        .press_pulse  (btn_press)
    );

`ifdef RST_WDT_EN
    localparam int            WW       = cnt_width(WDT_CYCLES, 1, 1);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

    logic [WW-1:0] wdt_cnt;

    // Fires on the cycle the count reaches its last value unless a kick
    // arrives in that same cycle.
    assign wdt_fire = (state == S_RUN) && !bus.wdt_kick && (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk_in) begin
        if (!rst_n || state != S_RUN || bus.wdt_kick) begin
            wdt_cnt <= '0;
        end else if (!wdt_fire) begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end
`else
    localparam int unused_wdt_cycles = WDT_CYCLES;
    logic          unused_wdt_kick;

    assign unused_wdt_kick = bus.wdt_kick;
    assign wdt_fire        = 1'b0;
`endif

    // Shift one more released domain in from the bottom.
    assign next_mask = (out_n_q << 1) | FIRST_MASK;
    assign req_any   = btn_press | bus.sw_rst_req | wdt_fire;

    always_comb begin
        req_cause = CAUSE_SW;
        if (btn_press) begin
            req_cause = CAUSE_BTN;
        end else if (wdt_fire) begin
            req_cause = CAUSE_WDT;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state   <= S_POR;
            cnt     <= '0;
            out_n_q <= '0;
            done_q  <= 1'b0;
            cause_q <= CAUSE_POR;
        end else if ((state == S_RELEASE || state == S_RUN) && req_any) begin
            // A request during release aborts the partial release.
            out_n_q <= '0;
            done_q  <= 1'b0;
            cause_q <= req_cause;
            cnt     <= '0;
            state   <= S_ASSERT;
        end else begin
            case (state)
                S_POR: begin
                    if (cnt == POR_LAST) begin
                        out_n_q <= FIRST_MASK;
                        cnt     <= '0;
                        if (NUM_DOMAINS == 1) begin
                            done_q <= 1'b1;
                            state  <= S_RUN;
                        end else begin
                            state <= S_RELEASE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (cnt == STAGE_LAST) begin
                        out_n_q <= next_mask;
                        cnt     <= '0;
                        if (&next_mask) begin
                            done_q <= 1'b1;
                            state  <= S_RUN;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    cnt <= '0;
                end
                S_ASSERT: begin
                    // The hold time only starts once the button is let go.
                    if (btn_level) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        out_n_q <= FIRST_MASK;
                        cnt     <= '0;
                        if (NUM_DOMAINS == 1) begin
                            done_q <= 1'b1;
                            state  <= S_RUN;
                        end else begin
                            state <= S_RELEASE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_POR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.rst_out_n = out_n_q;
    assign bus.rst_done  = done_q;
    assign bus.rst_cause = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - self-checking bench for rst_sequencer
module tb_rst_sequencer;
    localparam int POR  = 10;
    localparam int ND   = 3;
    localparam int STG  = 4;
    localparam int DEB  = 8;
    localparam int HOLD = 6;
    localparam int WDT  = 20;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rst_sequencer_if #(.NUM_DOMAINS(ND)) bus ();

    rst_sequencer #(
        .POR_CYCLES     (POR),
        .NUM_DOMAINS    (ND),
        .STAGE_CYCLES   (STG),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .BTN_ACTIVE_LOW (1'b1),
        .WDT_CYCLES     (WDT)
    ) dut (
        .clk_in(clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [ND-1:0] out_n;
        logic        done;
        logic [1:0]  cause;
        string       tag;
    } exp_t;

    typedef struct {
        string         tag;
        int            d;
        logic [ND-1:0] pre_out;
        logic          pre_done;
        logic          accept;
    } vec_t;

    exp_t sb[$];
    int   edge_n   = 0;
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic expect_at(input int cyc, input logic [ND-1:0] o, input logic dn,
                             input logic [1:0] c, input string tag);
        exp_t e;
        e.cyc   = cyc;
        e.out_n = o;
        e.done  = dn;
        e.cause = c;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic check_due();
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != edge_n || bus.rst_out_n !== e.out_n || bus.rst_done !== e.done ||
                bus.rst_cause !== e.cause) begin
                n_fails++;
                $display("FAIL %s edge %0d (due %0d): out_n=%b done=%b cause=%0d, want out_n=%b done=%b cause=%0d",
                         e.tag, edge_n, e.cyc, bus.rst_out_n, bus.rst_done, bus.rst_cause,
                         e.out_n, e.done, e.cause);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
        check_due();
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain_timeout edge %0d: %0d expectations pending, want 0", edge_n, sb.size());
            sb.delete();
        end
    endtask

    // Expected sequence: all low at drop, first domain up lat edges later,
    // then one more domain every STG edges; rst_done with the last one.
    task automatic push_seq(input int drop, input int lat, input logic [1:0] cause,
                            input int from, output int run_edge);
        int rel;
        logic [ND-1:0] m;
        logic [ND-1:0] prev;
        rel = drop + lat;
        m   = '0;
        if (drop >= from) expect_at(drop, '0, 1'b0, cause, "outputs_drop");
        if (lat > 1 && rel - 1 >= from) expect_at(rel - 1, '0, 1'b0, cause, "hold_last");
        for (int k = 0; k < ND; k++) begin
            int t;
            t    = rel + k * STG;
            prev = m;
            m    = (m << 1) | ND'(1);
            if (k > 0 && t - 1 >= from) expect_at(t - 1, prev, 1'b0, cause, "stage_wait");
            if (t >= from) expect_at(t, m, (k == ND - 1), cause, "stage_release");
        end
        run_edge = rel + (ND - 1) * STG;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout edge %0d: simulation did not finish", edge_n);
        $fatal(1, "timeout");
    end

    initial begin
        int   run_e;
        int   d0;
        int   b;
        int   f;
        int   r;
        int   x;
        vec_t vecs[6];

        vecs[0] = '{"sw_in_assert_dropped", 3,  3'b000, 1'b0, 1'b0};
        vecs[1] = '{"sw_last_assert_edge",  6,  3'b000, 1'b0, 1'b0};
        vecs[2] = '{"sw_abort_at_001",      7,  3'b001, 1'b0, 1'b1};
        vecs[3] = '{"sw_abort_at_011",      11, 3'b011, 1'b0, 1'b1};
        vecs[4] = '{"sw_abort_final_stage", 14, 3'b011, 1'b0, 1'b1};
        vecs[5] = '{"sw_in_run",            20, 3'b111, 1'b1, 1'b1};

        rst_n          = 1'b0;
        bus.btn_rst_in = 1'b1;
        bus.sw_rst_req = 1'b0;
        bus.wdt_kick   = 1'b1;

        // Reset state, then power-on with a software request ignored in S_POR.
        expect_at(2, 3'b000, 1'b0, 2'd0, "reset_state");
        expect_at(3, 3'b000, 1'b0, 2'd0, "reset_state");
        tick(); tick(); tick();
        x = edge_n;
        push_seq(x, POR, 2'd0, x + 1, run_e);
        rst_n = 1'b1;
        run_to(x + 4);
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        drain();

        // Software requests placed at various points of a restart.
        for (int i = 0; i < 6; i++) begin
            d0 = edge_n + 1;
            expect_at(d0, 3'b000, 1'b0, 2'd2, "sw_run_drop");
            bus.sw_rst_req = 1'b1;
            tick();
            bus.sw_rst_req = 1'b0;
            expect_at(d0 + vecs[i].d - 1, vecs[i].pre_out, vecs[i].pre_done, 2'd2, vecs[i].tag);
            run_to(d0 + vecs[i].d - 1);
            if (vecs[i].accept)
                push_seq(d0 + vecs[i].d, HOLD, 2'd2, d0 + vecs[i].d, run_e);
            else
                push_seq(d0, HOLD, 2'd2, d0 + vecs[i].d, run_e);
            bus.sw_rst_req = 1'b1;
            tick();
            bus.sw_rst_req = 1'b0;
            drain();
        end

        // Bouncing button, with a software request on the press edge.
        x = edge_n;
        b = x + 1;
        f = b + 7;
        r = f + 20;
        expect_at(b + 6, 3'b111, 1'b1, 2'd2, "bounce_ignored");
        expect_at(f + DEB + 1, 3'b111, 1'b1, 2'd2, "press_not_early");
        expect_at(f + DEB + 2, 3'b000, 1'b0, 2'd1, "btn_over_sw");
        expect_at(f + 20, 3'b000, 1'b0, 2'd1, "held_while_pressed");
        push_seq(r + DEB + 1, HOLD, 2'd1, r + DEB + 1, run_e);
        expect_at(run_e + 8, 3'b111, 1'b1, 2'd1, "single_press");
        bus.btn_rst_in = 1'b0;
        run_to(b + 4);
        bus.btn_rst_in = 1'b1;
        run_to(b + 6);
        bus.btn_rst_in = 1'b0;
        run_to(f + DEB + 1);
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        run_to(r - 1);
        bus.btn_rst_in = 1'b1;
        drain();

        // One-cycle hard reset mid-run.
        x = edge_n;
        push_seq(x + 1, POR, 2'd0, x + 1, run_e);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drain();

`ifdef RST_WDT_EN
        x = edge_n;
        bus.wdt_kick = 1'b0;
        expect_at(x + WDT - 1, 3'b111, 1'b1, 2'd0, "wdt_not_early");
        push_seq(x + WDT, HOLD, 2'd3, x + WDT, run_e);
        drain();
        x = edge_n;
        expect_at(x + 20, 3'b111, 1'b1, 2'd3, "wdt_kicked");
        expect_at(x + 40, 3'b111, 1'b1, 2'd3, "wdt_kicked");
        expect_at(x + 60, 3'b111, 1'b1, 2'd3, "wdt_kicked");
        for (int i = 1; i <= 60; i++) begin
            bus.wdt_kick = (i % 15 == 0);
            tick();
        end
        bus.wdt_kick = 1'b1;
`else
        x = edge_n;
        bus.wdt_kick = 1'b0;
        expect_at(x + WDT, 3'b111, 1'b1, 2'd0, "no_wdt_built");
        expect_at(x + 3 * WDT, 3'b111, 1'b1, 2'd0, "no_wdt_built");
        run_to(x + 3 * WDT);
        bus.wdt_kick = 1'b1;
`endif
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
